axi_lite_master_sequencer: RTL and testbench
============================================

Name: axi_lite_master_sequencer

Overview:
Command-driven AXI4-Lite master that turns single read/write commands into protocol-correct AXI-Lite transactions toward one slave, e.g. the LED register slave or its slave BFM in simulation. Only one transaction is outstanding at a time. It returns the response (read data plus RESP) on a response handshake. A watchdog counter flags slaves that stall a handshake.

Parameters:
C_M_AXI_ADDR_WIDTH, 32, AXI address width
C_M_AXI_DATA_WIDTH, 32, AXI data width (32 or 64)
C_AXPROT, 3'b000, constant value driven on AWPROT/ARPROT
C_TIMEOUT, 1024, watchdog cycle limit per transaction; 0 disables the watchdog

Ports:
ACLK  in  1  clock; all logic is rising-edge
ARESET  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_we  in  1  1=write, 0=read
cmd_addr  in  ADDR  byte address
cmd_wdata  in  DATA  write data (ignored for reads)
cmd_wstrb  in  DATA/8  write strobes (ignored for reads)
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
rsp_rdata  out  DATA  read data; 0 after a write
rsp_resp  out  2  BRESP or RRESP of the transaction
rsp_we  out  1  echo of cmd_we
timeout  out  1  one-cycle pulse when the watchdog expires
timeout_flag  out  1  sticky; cleared on the next command accept
M_AXI_AWADDR  out  ADDR; M_AXI_AWPROT out 3; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1
M_AXI_WDATA  out  DATA; M_AXI_WSTRB out DATA/8; M_AXI_WVALID out 1; M_AXI_WREADY in 1
M_AXI_BRESP  in  2; M_AXI_BVALID in 1; M_AXI_BREADY out 1
M_AXI_ARADDR  out  ADDR; M_AXI_ARPROT out 3; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1
M_AXI_RDATA  in  DATA; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1

Behaviour:
- Clock and reset: one clock ACLK; ARESET is synchronous and active-high.
- Reset values: state=IDLE. All VALID/READY outputs, rsp_valid, timeout and timeout_flag are 0. cmd_ready=0 while ARESET=1. Address, data and rsp registers are 0.
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - cmd_ready=1.
  - On accept, latch addr/wdata/wstrb/we into the M_AXI address/data registers.
  - Write -> WR with AWVALID=WVALID=1 from the next cycle. Read -> RD_ADDR with ARVALID=1 from the next cycle.
- WR:
  - AWVALID and WVALID each drop on the cycle after their own handshake (VALID&READY sampled at the edge). Their order is independent; both may complete in the same cycle.
  - Payload is held stable until its handshake.
  - When both handshakes are done -> WR_RESP.
- WR_RESP: BREADY=1. On BVALID, latch BRESP into rsp_resp, set rsp_rdata=0 -> RSP.
- RD_ADDR: ARVALID held until ARREADY -> RD_DATA.
- RD_DATA: RREADY=1. On RVALID, latch RDATA/RRESP -> RSP.
- RSP: rsp_valid=1 and rsp outputs stable until rsp_ready; then -> IDLE with cmd_ready=1 the next cycle. No back-to-back bypass.
- VALID signals never depend combinationally on READY inputs; all M_AXI outputs are registered.
- Minimum latency with a zero-wait slave:
  - Write: accept at cycle 0, AW/W handshake at cycle 1, B handshake at cycle 2, rsp_valid at cycle 3.
  - Read: accept at cycle 0, AR at cycle 1, R at cycle 2, rsp_valid at cycle 3.
- Watchdog:
  - A cycle counter clears on command accept and increments in WR, WR_RESP, RD_ADDR and RD_DATA.
  - When count reaches C_TIMEOUT-1: timeout pulses for 1 cycle and timeout_flag sets.
  - The transaction is not aborted, which keeps AXI compliant. The counter saturates, so there is only one pulse per transaction.
  - C_TIMEOUT=0 means the counter and flags stay 0.
- The counter does not run in RSP; rsp_ready stall is not a slave fault.
- Non-OKAY RESP is passed through unchanged; no retry.
- ARESET mid-transaction returns to IDLE and drops all VALIDs next cycle. The bench must reset the slave at the same time.

Test Plan:
1. Zero-wait write: addr 0x0, wdata 0x0000_000A, wstrb 4'hF -> AWADDR=0x0 and WDATA=0xA handshake at cycle 1, BREADY at cycle 2, rsp_valid at cycle 3 with rsp_resp=2'b00, rsp_rdata=0, rsp_we=1.
2. Skewed write: slave AWREADY at +1 cycle, WREADY at +4 cycles -> AWVALID drops after its handshake, WVALID and WDATA are held until +4, exactly one B handshake.
3. Read 0x4 with RVALID delayed 3 cycles, RDATA=0x5, RRESP=2'b10 -> rsp_rdata=0x5, rsp_resp=2'b10; RREADY high only in RD_DATA.
4. rsp_ready held 0 for 5 cycles -> rsp stays stable, cmd_ready=0, no new AW/AR issued; accept resumes the cycle after rsp_ready.
5. C_TIMEOUT=8, AWREADY withheld 20 cycles -> single timeout pulse at the 8th busy cycle, timeout_flag=1 until the next cmd accept, transaction still completes with OKAY.
6. ARESET asserted while in WR_RESP -> next cycle all VALIDs/READYs=0, rsp_valid=0, cmd_ready=1 after ARESET deasserts; a following read of 0x0 completes normally.

Source files
------------

// File: rtl/axi_lite_master_sequencer.sv
// ---------------------------------------------------------------------------
// axi_lite_master_sequencer
//
// Turns single read/write commands into AXI4-Lite transactions toward one
// slave. Only one transaction is in flight at a time. The result (read data
// plus RESP) comes back on a valid/ready response port. A watchdog flags a
// slave that stalls a handshake, but it never aborts the transaction.
//
// Ports
//   ACLK, ARESET        rising-edge clock, synchronous active-high reset
//   cmd_*               command in  (valid/ready, we, addr, wdata, wstrb)
//   rsp_*               response out (valid/ready, rdata, resp, we echo)
//   timeout             one-cycle pulse when the watchdog expires
//   timeout_flag        sticky watchdog flag, cleared on the next command accept
//   M_AXI_*             AXI4-Lite master channels AW, W, B, AR, R
// ---------------------------------------------------------------------------
module axi_lite_master_sequencer #(
  parameter int         C_M_AXI_ADDR_WIDTH = 32,
  parameter int         C_M_AXI_DATA_WIDTH = 32,
  parameter logic [2:0] C_AXPROT           = 3'b000,
  parameter int         C_TIMEOUT          = 1024
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  // command port
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_we,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  // response port
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_we,
  // watchdog
  output logic                            timeout,
  output logic                            timeout_flag,
  // write address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  // write data channel
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  // write response channel
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  // read address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  // read data channel
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SW = C_M_AXI_DATA_WIDTH / 8;

  // Watchdog counter is wide enough to hold C_TIMEOUT itself (its saturation
  // value) and is at least one bit wide even when the watchdog is disabled.
  localparam int            CNT_W    = $clog2(C_TIMEOUT + 2);
  localparam bit            WD_EN    = (C_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(C_TIMEOUT);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'((C_TIMEOUT > 0) ? C_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t            state_q,     state_d;
  logic [AW-1:0]     addr_q,      addr_d;
  logic [DW-1:0]     wdata_q,     wdata_d;
  logic [SW-1:0]     wstrb_q,     wstrb_d;
  logic              we_q,        we_d;
  logic              awvalid_q,   awvalid_d;
  logic              wvalid_q,    wvalid_d;
  logic              bready_q,    bready_d;
  logic              arvalid_q,   arvalid_d;
  logic              rready_q,    rready_d;
  logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_resp_q,  rsp_resp_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              tflag_q,     tflag_d;

  logic cmd_accept;
  logic busy;
  logic timeout_hit;

  assign cmd_ready  = (state_q == IDLE) && !ARESET;
  assign cmd_accept = cmd_valid && cmd_ready;
  // Only states waiting on the slave count toward the watchdog; a stalled
  // rsp_ready is the requester's business, not a slave fault.
  assign busy       = (state_q == WR) || (state_q == WR_RESP) ||
                      (state_q == RD_ADDR) || (state_q == RD_DATA);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    we_d        = we_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    cnt_d       = cnt_q;
    tflag_d     = tflag_q;
    timeout_hit = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_accept) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          we_d    = cmd_we;
          if (cmd_we) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end

      WR: begin
        // AW and W retire independently; each VALID falls after its own
        // handshake, and the pair may complete in the same cycle.
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (M_AXI_BVALID) begin
          rsp_resp_d  = M_AXI_BRESP;
          rsp_rdata_d = '0;
          bready_d    = 1'b0;
          state_d     = RSP;
        end
      end

      RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (M_AXI_RVALID) begin
          rsp_rdata_d = M_AXI_RDATA;
          rsp_resp_d  = M_AXI_RRESP;
          rready_d    = 1'b0;
          state_d     = RSP;
        end
      end

      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Watchdog: saturating at LIMIT means the LIMIT-1 match happens once,
    // giving a single pulse per transaction.
    if (WD_EN) begin
      timeout_hit = busy && (cnt_q == LIMIT_M1);
      if (cmd_accept) begin
        cnt_d   = '0;
        tflag_d = 1'b0;
      end else if (busy && (cnt_q != LIMIT)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (timeout_hit) tflag_d = 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values; the design holds no memories, so everything is reset.
    if (ARESET) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      we_q        <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      cnt_q       <= '0;
      tflag_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      we_q        <= we_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      cnt_q       <= cnt_d;
      tflag_q     <= tflag_d;
    end
  end

  // One address register serves both channels; only one is ever valid.
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = C_AXPROT;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = C_AXPROT;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

  assign rsp_valid    = (state_q == RSP);
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_resp     = rsp_resp_q;
  assign rsp_we       = we_q;
  assign timeout      = timeout_hit;
  assign timeout_flag = tflag_q;

endmodule

// File: tb/tb_axi_lite_master_sequencer.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_master_sequencer
//
// Self-checking bench: a delay-configurable AXI4-Lite slave model, a command
// driver that pushes the expected response into a queue, and a response
// consumer that pops and compares it. The DUT watchdog is set to 8 cycles.
// ---------------------------------------------------------------------------
module tb_axi_lite_master_sequencer;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic          ACLK   = 1'b0;
  logic          ARESET = 1'b1;
  logic          cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic          cmd_ready;
  logic          rsp_valid, rsp_we;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          timeout, timeout_flag;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [2:0]    AWPROT, ARPROT;
  logic          AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic [DW-1:0] WDATA;
  logic [SW-1:0] WSTRB;
  logic          AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0;
  logic          ARREADY = 1'b0, RVALID = 1'b0;
  logic [1:0]    BRESP = '0, RRESP = '0;
  logic [DW-1:0] RDATA = '0;

  axi_lite_master_sequencer #(
    .C_M_AXI_ADDR_WIDTH (AW),
    .C_M_AXI_DATA_WIDTH (DW),
    .C_AXPROT           (3'b000),
    .C_TIMEOUT          (TO)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_we        (cmd_we),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_wstrb     (cmd_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .rsp_we        (rsp_we),
    .timeout       (timeout),
    .timeout_flag  (timeout_flag),
    .M_AXI_AWADDR  (AWADDR),
    .M_AXI_AWPROT  (AWPROT),
    .M_AXI_AWVALID (AWVALID),
    .M_AXI_AWREADY (AWREADY),
    .M_AXI_WDATA   (WDATA),
    .M_AXI_WSTRB   (WSTRB),
    .M_AXI_WVALID  (WVALID),
    .M_AXI_WREADY  (WREADY),
    .M_AXI_BRESP   (BRESP),
    .M_AXI_BVALID  (BVALID),
    .M_AXI_BREADY  (BREADY),
    .M_AXI_ARADDR  (ARADDR),
    .M_AXI_ARPROT  (ARPROT),
    .M_AXI_ARVALID (ARVALID),
    .M_AXI_ARREADY (ARREADY),
    .M_AXI_RDATA   (RDATA),
    .M_AXI_RRESP   (RRESP),
    .M_AXI_RVALID  (RVALID),
    .M_AXI_RREADY  (RREADY)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic          we;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
  } rsp_t;
  rsp_t exp_q[$];

  // ---------------- slave model ----------------
  int            aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]    bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [DW-1:0] rdata_cfg = '0;

  int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0, to_n = 0;
  int bready_n = 0, rready_n = 0, viol = 0;
  int aw_cyc = 0, w_cyc = 0, b_cyc = 0, ar_cyc = 0, r_cyc = 0, to_cyc = 0;
  logic [AW-1:0] cap_awaddr = '0, cap_araddr = '0;
  logic [DW-1:0] cap_wdata = '0;
  logic [SW-1:0] cap_wstrb = '0;

  // Everything happens at the falling edge: handshakes decided here complete
  // at the following rising edge and are retired at the next falling edge.
  initial begin : slave
    bit aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    bit aw_hold = 0, w_hold = 0, ar_hold = 0;
    bit aw_got = 0, w_got = 0, b_owed = 0, r_owed = 0;
    int aw_w = 0, w_w = 0, b_w = 0, ar_w = 0, r_w = 0;
    logic [AW-1:0] h_awaddr = '0, h_araddr = '0;
    logic [DW-1:0] h_wdata = '0;
    logic [SW-1:0] h_wstrb = '0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
        BRESP = '0; RRESP = '0; RDATA = '0;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        aw_hold = 0; w_hold = 0; ar_hold = 0;
        aw_got = 0; w_got = 0; b_owed = 0; r_owed = 0;
        aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0;
      end else begin
        // pending VALIDs must stay up with a stable payload
        if (aw_hold && (!AWVALID || AWADDR !== h_awaddr)) viol++;
        if (w_hold && (!WVALID || WDATA !== h_wdata || WSTRB !== h_wstrb)) viol++;
        if (ar_hold && (!ARVALID || ARADDR !== h_araddr)) viol++;
        // retire handshakes completed at the last rising edge
        if (aw_hs) begin AWREADY = 0; aw_n++; aw_got = 1; end
        if (w_hs)  begin WREADY = 0;  w_n++;  w_got = 1;  end
        if (b_hs)  begin BVALID = 0;  b_n++; end
        if (ar_hs) begin ARREADY = 0; ar_n++; r_owed = 1; r_w = 0; end
        if (r_hs)  begin RVALID = 0;  r_n++; end
        if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_owed = 1; b_w = 0; end
        // raise READY/VALID after the configured wait
        if (AWVALID && !AWREADY) begin
          if (aw_w >= aw_delay) begin AWREADY = 1; aw_w = 0; end else aw_w++;
        end
        if (WVALID && !WREADY) begin
          if (w_w >= w_delay) begin WREADY = 1; w_w = 0; end else w_w++;
        end
        if (ARVALID && !ARREADY) begin
          if (ar_w >= ar_delay) begin ARREADY = 1; ar_w = 0; end else ar_w++;
        end
        if (b_owed && !BVALID) begin
          if (b_w >= b_delay) begin BVALID = 1; BRESP = bresp_cfg; b_owed = 0; end else b_w++;
        end
        if (r_owed && !RVALID) begin
          if (r_w >= r_delay) begin
            RVALID = 1; RDATA = rdata_cfg; RRESP = rresp_cfg; r_owed = 0;
          end else r_w++;
        end
        // handshakes that will complete at the coming rising edge
        aw_hs = AWVALID && AWREADY;
        w_hs  = WVALID && WREADY;
        b_hs  = BVALID && BREADY;
        ar_hs = ARVALID && ARREADY;
        r_hs  = RVALID && RREADY;
        if (aw_hs) begin cap_awaddr = AWADDR; aw_cyc = cyc; end
        if (w_hs)  begin cap_wdata = WDATA; cap_wstrb = WSTRB; w_cyc = cyc; end
        if (b_hs)  b_cyc = cyc;
        if (ar_hs) begin cap_araddr = ARADDR; ar_cyc = cyc; end
        if (r_hs)  r_cyc = cyc;
        aw_hold = AWVALID && !aw_hs; h_awaddr = AWADDR;
        w_hold  = WVALID && !w_hs;   h_wdata = WDATA; h_wstrb = WSTRB;
        ar_hold = ARVALID && !ar_hs; h_araddr = ARADDR;
        if (BREADY) bready_n++;
        if (RREADY) rready_n++;
        if (timeout) begin to_n++; to_cyc = cyc; end
      end
    end
  end

  // ---------------- driver / response consumer ----------------
  task automatic step();
    @(negedge ACLK);
    #1;
  endtask

  task automatic do_txn(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [SW-1:0] wstrb, input int hold,
                        input logic [DW-1:0] exp_rdata, input logic [1:0] exp_resp,
                        output int t0, output int lat);
    int   n;
    int   hv;
    rsp_t e;
    logic [DW+2:0] r0;
    n = 0;
    while (!cmd_ready && n < 50) begin step(); n++; end
    if (!cmd_ready) check("cmd_ready_wait", 0, 1);
    cmd_valid = 1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = wstrb;
    t0 = cyc;
    e.we = we; e.rdata = exp_rdata; e.resp = exp_resp;
    exp_q.push_back(e);
    step();
    // scramble the command bus so only latched values can reach the slave
    cmd_valid = 0; cmd_we = 0; cmd_addr = '1; cmd_wdata = '1; cmd_wstrb = '1;
    n = 0;
    while (!rsp_valid && n < 100) begin step(); n++; end
    lat = cyc - t0;
    if (!rsp_valid) begin
      check("rsp_wait", 0, 1);
      void'(exp_q.pop_front());
      return;
    end
    r0 = {rsp_we, rsp_resp, rsp_rdata};
    hv = 0;
    for (int i = 0; i < hold; i++) begin
      step();
      if ({rsp_we, rsp_resp, rsp_rdata} !== r0 || !rsp_valid || cmd_ready || AWVALID || ARVALID)
        hv++;
    end
    if (hold > 0) check("rsp_hold", hv, 0);
    rsp_ready = 1;
    e = exp_q.pop_front();
    check("rsp_we", rsp_we, e.we);
    check("rsp_resp", rsp_resp, e.resp);
    check("rsp_rdata", rsp_rdata, e.rdata);
    step();
    rsp_ready = 0;
    check("post_rsp_valid_ready", {rsp_valid, cmd_ready}, 2'b01);
  endtask

  task automatic set_delays(input int aw, input int w, input int b, input int ar, input int r);
    aw_delay = aw; w_delay = w; b_delay = b; ar_delay = ar; r_delay = r;
  endtask

  initial begin : global_guard
    #100000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int t0, lat, b0, a0, w0, bn0, r0, to0;

    // reset state
    ARESET = 1;
    repeat (3) step();
    check("rst_ctl", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, cmd_ready,
                      timeout, timeout_flag}, 0);
    check("rst_awaddr", AWADDR, 0);
    check("rst_wdata", WDATA, 0);
    check("rst_rsp", {rsp_resp, rsp_rdata}, 0);
    ARESET = 0;
    #1;
    check("cmd_ready_after_rst", cmd_ready, 1);

    // 1: zero-wait write
    set_delays(0, 0, 0, 0, 0); bresp_cfg = 2'b00;
    b0 = bready_n;
    do_txn(1, 32'h0, 32'h0000_000A, 4'hF, 0, 32'h0, 2'b00, t0, lat);
    check("t1_lat", lat, 3);
    check("t1_aw_cyc", aw_cyc - t0, 1);
    check("t1_w_cyc", w_cyc - t0, 1);
    check("t1_b_cyc", b_cyc - t0, 2);
    check("t1_awaddr", cap_awaddr, 32'h0);
    check("t1_wdata", cap_wdata, 32'hA);
    check("t1_wstrb", cap_wstrb, 4'hF);
    check("t1_bready_cycles", bready_n - b0, 1);

    // 2: skewed write, non-OKAY BRESP passed through
    set_delays(1, 4, 0, 0, 0); bresp_cfg = 2'b11;
    a0 = aw_n; w0 = w_n; bn0 = b_n;
    do_txn(1, 32'h10, 32'hDEAD_BEEF, 4'h5, 0, 32'h0, 2'b11, t0, lat);
    check("t2_aw_cyc", aw_cyc - t0, 2);
    check("t2_w_cyc", w_cyc - t0, 5);
    check("t2_aw_count", aw_n - a0, 1);
    check("t2_w_count", w_n - w0, 1);
    check("t2_b_count", b_n - bn0, 1);
    check("t2_awaddr", cap_awaddr, 32'h10);
    check("t2_wdata", cap_wdata, 32'hDEAD_BEEF);
    check("t2_wstrb", cap_wstrb, 4'h5);
    check("t2_payload_stable", viol, 0);

    // 3: read with delayed RVALID and SLVERR
    set_delays(0, 0, 0, 0, 3); rdata_cfg = 32'h5; rresp_cfg = 2'b10;
    r0 = rready_n;
    do_txn(0, 32'h4, 32'h1234, 4'h0, 0, 32'h5, 2'b10, t0, lat);
    check("t3_araddr", cap_araddr, 32'h4);
    check("t3_ar_cyc", ar_cyc - t0, 1);
    check("t3_r_cyc", r_cyc - t0, 5);
    check("t3_lat", lat, 6);
    check("t3_rready_cycles", rready_n - r0, 4);

    // 4: stalled rsp_ready on a write that follows a read (rdata must be 0)
    set_delays(0, 0, 0, 0, 0); bresp_cfg = 2'b00;
    do_txn(1, 32'h8, 32'h77, 4'h3, 5, 32'h0, 2'b00, t0, lat);
    check("t4_lat", lat, 3);

    // 5: watchdog with AWREADY withheld 20 cycles
    set_delays(20, 0, 0, 0, 0);
    to0 = to_n;
    do_txn(1, 32'hC, 32'h55, 4'hF, 0, 32'h0, 2'b00, t0, lat);
    check("t5_timeout_pulses", to_n - to0, 1);
    check("t5_timeout_cyc", to_cyc - t0, TO);
    check("t5_flag_sticky", timeout_flag, 1);
    check("t5_aw_cyc", aw_cyc - t0, 21);
    set_delays(0, 0, 0, 0, 0); rdata_cfg = 32'h99; rresp_cfg = 2'b00;
    do_txn(0, 32'h0, 32'h0, 4'h0, 0, 32'h99, 2'b00, t0, lat);
    check("t5_flag_cleared", timeout_flag, 0);
    check("t5_no_new_pulse", to_n - to0, 1);

    // 6: reset while waiting in WR_RESP
    set_delays(0, 0, 10, 0, 0);
    cmd_valid = 1; cmd_we = 1; cmd_addr = 32'h20; cmd_wdata = 32'hAB; cmd_wstrb = 4'hF;
    step();
    cmd_valid = 0;
    step();
    step();
    check("t6_in_wr_resp", {BREADY, rsp_valid}, 2'b10);
    ARESET = 1;
    step();
    check("t6_rst_ctl", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, cmd_ready}, 0);
    ARESET = 0;
    #1;
    check("t6_cmd_ready", cmd_ready, 1);
    set_delays(0, 0, 0, 0, 0); rdata_cfg = 32'h3C; rresp_cfg = 2'b00;
    do_txn(0, 32'h0, 32'h0, 4'h0, 0, 32'h3C, 2'b00, t0, lat);
    check("t6_read_lat", lat, 3);
    check("t6_araddr", cap_araddr, 32'h0);

    check("sb_empty", exp_q.size(), 0);
    check("protocol_stable", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
